// File: rtl/procesor_pkg.sv
// Shared processor constants and the fetch-unit state type.
package procesor_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic {
    RUN,
    HALT
  } stan_e;

endpackage

// File: rtl/licznik_pc.sv
// Program counter: register, sequential increment and jump mux (jump wins).
module licznik_pc #(
  parameter int unsigned ADDR_WIDTH = procesor_pkg::ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inc_i,
  input  logic                  jmp_i,
  input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (jmp_i) begin
      pc_d = jmp_addr_i;
    end else if (inc_i) begin
      // Truncation to ADDR_WIDTH gives the modulo wrap.
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/jednostka_pobierania.sv
// Instruction fetch unit: RUN/HALT FSM, instruction register and ready/valid handshake.
// Optional macro FETCH_WRAP_HALT_EN: halt after fetching the last address instead of wrapping.
module jednostka_pobierania
  import procesor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] pc_addr,
  input  logic [DATA_WIDTH-1:0] instr_in,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  jmp_en,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  input  logic                  halt,
  output logic                  halted
);

  stan_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_inc, pc_jmp;
  logic                  accept;

  licznik_pc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_licznik_pc (
    .clk_i     (clk),
    .rst_i     (rst),
    .inc_i     (pc_inc),
    .jmp_i     (pc_jmp),
    .jmp_addr_i(jmp_addr),
    .pc_o      (pc)
  );

  assign accept = valid_q & instr_ready;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    pc_inc  = 1'b0;
    pc_jmp  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt) begin
          // Halt discards a simultaneous jump; IR only drains via the handshake.
          state_d = HALT;
          if (accept) valid_d = 1'b0;
        end else if (jmp_en) begin
          pc_jmp  = 1'b1;
          valid_d = 1'b0;
        end else if (!valid_q || accept) begin
          ir_d    = instr_in;
          ipc_d   = pc;
          valid_d = 1'b1;
`ifdef FETCH_WRAP_HALT_EN
          if (pc == '1) begin
            state_d = HALT;
          end else begin
            pc_inc = 1'b1;
          end
`else
          pc_inc  = 1'b1;
`endif
        end
      end
      HALT: begin
        if (accept) valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ir_q    <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_addr     = pc;
  assign instr_out   = ir_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_jednostka_pobierania.sv
// Directed bench for jednostka_pobierania; ROM[i] = 16'h1000 + i. Honours FETCH_WRAP_HALT_EN.
module tb_jednostka_pobierania;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_addr;
  logic [15:0] instr_in;
  logic [15:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jmp_en;
  logic [7:0]  jmp_addr;
  logic        halt;
  logic        halted;

  int total = 0;
  int bad   = 0;

  jednostka_pobierania dut (
    .clk        (clk),
    .rst        (rst),
    .pc_addr    (pc_addr),
    .instr_in   (instr_in),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .halt       (halt),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign instr_in = 16'h1000 + {8'h00, pc_addr};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are checked and inputs driven on the falling edge.
  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b1; jmp_en = 1'b0; jmp_addr = 8'h00; halt = 1'b0;
    tick; tick;
    check_val("rst_pc", 32'(pc_addr), 32'h0);
    check_val("rst_valid", 32'(instr_valid), 32'h0);
    check_val("rst_ir", 32'(instr_out), 32'h0);
    check_val("rst_ipc", 32'(instr_pc), 32'h0);
    check_val("rst_halted", 32'(halted), 32'h0);

    rst = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      check_val("seq_ir", 32'(instr_out), 32'h1000 + 32'(i));
      check_val("seq_ipc", 32'(instr_pc), 32'(i));
      check_val("seq_valid", 32'(instr_valid), 32'h1);
      tick;
    end

    // Jump while IR holds address 3.
    check_val("jmp_pre_ipc", 32'(instr_pc), 32'h3);
    jmp_en = 1'b1; jmp_addr = 8'h40;
    tick;
    check_val("jmp_flush", 32'(instr_valid), 32'h0);
    check_val("jmp_pc", 32'(pc_addr), 32'h40);
    jmp_en = 1'b0;
    tick;
    check_val("jmp_ipc", 32'(instr_pc), 32'h40);
    check_val("jmp_ir", 32'(instr_out), 32'h1040);

    // Stall at instr_pc 5.
    jmp_en = 1'b1; jmp_addr = 8'h05;
    tick;
    jmp_en = 1'b0;
    tick;
    check_val("stall_pre_ipc", 32'(instr_pc), 32'h5);
    instr_ready = 1'b0;
    repeat (3) begin
      tick;
      check_val("stall_ir", 32'(instr_out), 32'h1005);
      check_val("stall_ipc", 32'(instr_pc), 32'h5);
      check_val("stall_pc", 32'(pc_addr), 32'h6);
      check_val("stall_valid", 32'(instr_valid), 32'h1);
    end
    instr_ready = 1'b1;
    tick;
    check_val("stall_next_ipc", 32'(instr_pc), 32'h6);
    check_val("stall_next_ir", 32'(instr_out), 32'h1006);

    // Sequential fetch across the top address.
    jmp_en = 1'b1; jmp_addr = 8'hFF;
    tick;
    jmp_en = 1'b0;
    tick;
    check_val("wrap_ipc", 32'(instr_pc), 32'hFF);
    check_val("wrap_ir", 32'(instr_out), 32'h10FF);
`ifdef FETCH_WRAP_HALT_EN
    check_val("wrap_halted", 32'(halted), 32'h1);
    check_val("wrap_pc_frozen", 32'(pc_addr), 32'hFF);
    tick;
    check_val("wrap_drain", 32'(instr_valid), 32'h0);
    check_val("wrap_pc_frozen2", 32'(pc_addr), 32'hFF);
`else
    check_val("wrap_halted", 32'(halted), 32'h0);
    check_val("wrap_pc", 32'(pc_addr), 32'h0);
    tick;
    check_val("wrap_next_ipc", 32'(instr_pc), 32'h0);
    check_val("wrap_next_ir", 32'(instr_out), 32'h1000);
`endif

    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_val("rst2_halted", 32'(halted), 32'h0);

    // Halt together with a jump at PC 0x10.
    jmp_en = 1'b1; jmp_addr = 8'h0F;
    tick;
    jmp_en = 1'b0;
    tick;
    check_val("halt_pre_pc", 32'(pc_addr), 32'h10);
    halt = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h80; instr_ready = 1'b0;
    tick;
    check_val("halt_halted", 32'(halted), 32'h1);
    check_val("halt_pc", 32'(pc_addr), 32'h10);
    check_val("halt_valid", 32'(instr_valid), 32'h1);
    check_val("halt_ipc", 32'(instr_pc), 32'h0F);
    halt = 1'b0;
    tick;
    check_val("halt_jmp_ignored", 32'(pc_addr), 32'h10);
    check_val("halt_valid_held", 32'(instr_valid), 32'h1);
    jmp_en = 1'b0; instr_ready = 1'b1;
    tick;
    check_val("halt_drain", 32'(instr_valid), 32'h0);
    check_val("halt_stays", 32'(halted), 32'h1);
    tick;
    check_val("halt_no_load", 32'(instr_valid), 32'h0);
    check_val("halt_pc_frozen", 32'(pc_addr), 32'h10);

    // Reset out of HALT while IR still valid.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    instr_ready = 1'b0; halt = 1'b1;
    tick;
    check_val("h2_halted", 32'(halted), 32'h1);
    check_val("h2_valid", 32'(instr_valid), 32'h1);
    halt = 1'b0; rst = 1'b1;
    tick;
    check_val("h2rst_pc", 32'(pc_addr), 32'h0);
    check_val("h2rst_valid", 32'(instr_valid), 32'h0);
    check_val("h2rst_halted", 32'(halted), 32'h0);
    check_val("h2rst_ir", 32'(instr_out), 32'h0);
    check_val("h2rst_ipc", 32'(instr_pc), 32'h0);
    rst = 1'b0; instr_ready = 1'b1;
    tick;
    check_val("resume_ir", 32'(instr_out), 32'h1000);
    check_val("resume_ipc", 32'(instr_pc), 32'h0);
    check_val("resume_valid", 32'(instr_valid), 32'h1);
    check_val("resume_pc", 32'(pc_addr), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
